// File: rtl/peri_timer_irq_pkg.sv
// Shared definitions for the peripheral timer/interrupt block: register map,
// CTRL bit positions, handshake FSM encoding and a byte-strobe merge helper.
package peri_timer_irq_pkg;

    localparam logic [4:0] OFF_CTRL      = 5'h00;
    localparam logic [4:0] OFF_LOAD      = 5'h04;
    localparam logic [4:0] OFF_COUNT     = 5'h08;
    localparam logic [4:0] OFF_STATUS    = 5'h0C;
    localparam logic [4:0] OFF_SWIRQ_SET = 5'h10;
    localparam logic [4:0] OFF_SWIRQ_CLR = 5'h14;

    localparam logic [31:0] WIN_BYTES = 32'd32;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int CTRL_W           = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_GAP  = 2'd2
    } hs_state_t;

    function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                               input logic [31:0] wd,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = wd[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/peri_timer_core.sv
// Free-running timer: COUNT increments while enabled, matches against LOAD,
// then either reloads to 0 or stops. Bus writes override the timer step.
module peri_timer_core
    import peri_timer_irq_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              ctrl_we,
    input  logic              load_we,
    input  logic              count_we,
    input  logic              pend_clr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    output logic [CTRL_W-1:0] ctrl,
    output logic [31:0]       load,
    output logic [31:0]       count,
    output logic              pend
);

    logic [CTRL_W-1:0] ctrl_nxt;
    logic [31:0]       count_nxt;
    logic              pend_set;

    always_comb begin
        ctrl_nxt  = ctrl;
        count_nxt = count;
        pend_set  = 1'b0;
        if (ctrl[CTRL_EN]) begin
            if (count == load) begin
                pend_set = 1'b1;
                if (ctrl[CTRL_AUTO_RELOAD]) count_nxt = '0;
                else                        ctrl_nxt[CTRL_EN] = 1'b0;
            end else begin
                count_nxt = count + 32'd1;
            end
        end
        // all CTRL bits live in byte lane 0
        if (ctrl_we && wstrb[0]) ctrl_nxt  = wdata[CTRL_W-1:0];
        else if (ctrl_we)        ctrl_nxt  = ctrl;
        if (count_we)            count_nxt = strb_merge(count, wdata, wstrb);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl  <= '0;
            load  <= '0;
            count <= '0;
            pend  <= 1'b0;
        end else begin
            ctrl  <= ctrl_nxt;
            count <= count_nxt;
            if (load_we) load <= strb_merge(load, wdata, wstrb);
            // an expiry in the same cycle as a clear keeps PEND set
            pend  <= pend_set | (pend & ~pend_clr);
        end
    end

endmodule

// File: rtl/peri_timer_irq.sv
// Memory-mapped timer and software interrupt controller with an
// IDLE/ACK/GAP request handshake and a registered interrupt bitmap.
module peri_timer_irq
    import peri_timer_irq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
    parameter int unsigned TIMER_IRQ_BIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        peri_rden,
    input  logic        peri_wren,
    input  logic [31:0] peri_addr,
    input  logic [31:0] peri_wdata,
    input  logic [3:0]  peri_wstrb,
    output logic [31:0] peri_rdata,
    output logic        peri_ready,
    output logic [31:0] irq_bitmap
);

    hs_state_t         state, state_nxt;
    logic [31:0]       off, rd_val, sw_pend, irq_nxt, wmask;
    logic [31:0]       tmr_load, tmr_count;
    logic [CTRL_W-1:0] tmr_ctrl;
    logic              tmr_pend;
    logic [4:0]        reg_off;
    logic              qual, in_win, accept, wr;
    logic              ctrl_we, load_we, count_we, pend_clr, sw_set_we, sw_clr_we;

    // top nibble 0 belongs to main memory and is never acknowledged here
    assign qual    = |peri_addr[31:28];
    assign off     = peri_addr - BASE_ADDR;
    assign in_win  = off < WIN_BYTES;
    assign reg_off = {off[4:2], 2'b00};
    assign accept  = (state == ST_IDLE) && (peri_rden || peri_wren) && qual;
    assign wr      = accept && peri_wren && in_win;
    assign wmask   = {{8{peri_wstrb[3]}}, {8{peri_wstrb[2]}},
                      {8{peri_wstrb[1]}}, {8{peri_wstrb[0]}}};

    assign ctrl_we   = wr && (reg_off == OFF_CTRL);
    assign load_we   = wr && (reg_off == OFF_LOAD);
    assign count_we  = wr && (reg_off == OFF_COUNT);
    assign pend_clr  = wr && (reg_off == OFF_STATUS) && peri_wstrb[0] && peri_wdata[0];
    assign sw_set_we = wr && (reg_off == OFF_SWIRQ_SET);
    assign sw_clr_we = wr && (reg_off == OFF_SWIRQ_CLR);

    peri_timer_core u_core (
        .clk      (clk),
        .resetn   (resetn),
        .ctrl_we  (ctrl_we),
        .load_we  (load_we),
        .count_we (count_we),
        .pend_clr (pend_clr),
        .wdata    (peri_wdata),
        .wstrb    (peri_wstrb),
        .ctrl     (tmr_ctrl),
        .load     (tmr_load),
        .count    (tmr_count),
        .pend     (tmr_pend)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_ACK;
            ST_ACK:  state_nxt = ST_GAP;
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        if (in_win) begin
            case (reg_off)
                OFF_CTRL:      rd_val = {{(32-CTRL_W){1'b0}}, tmr_ctrl};
                OFF_LOAD:      rd_val = tmr_load;
                OFF_COUNT:     rd_val = tmr_count;
                OFF_STATUS:    rd_val = {31'b0, tmr_pend};
                OFF_SWIRQ_SET: rd_val = sw_pend;
                OFF_SWIRQ_CLR: rd_val = sw_pend;
                default:       rd_val = '0;
            endcase
        end
    end

    always_comb begin
        irq_nxt                = sw_pend;
        irq_nxt[TIMER_IRQ_BIT] = tmr_pend & tmr_ctrl[CTRL_IRQ_EN];
        irq_nxt[2:0]           = 3'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            peri_rdata <= '0;
            sw_pend    <= '0;
            irq_bitmap <= '0;
        end else begin
            state      <= state_nxt;
            peri_rdata <= (accept && peri_rden) ? rd_val : 32'd0;
            irq_bitmap <= irq_nxt;
            if (sw_set_we)      sw_pend <= sw_pend | (peri_wdata & wmask);
            else if (sw_clr_we) sw_pend <= sw_pend & ~(peri_wdata & wmask);
        end
    end

    assign peri_ready = (state == ST_ACK);

endmodule

// File: tb/tb_peri_timer_irq.sv
// Randomized bench for peri_timer_irq against a cycle-level register model.
module tb_peri_timer_irq;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          TBIT = 4;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        peri_rden = 1'b0, peri_wren = 1'b0;
    logic [31:0] peri_addr = '0, peri_wdata = '0;
    logic [3:0]  peri_wstrb = '0;
    logic [31:0] peri_rdata, irq_bitmap;
    logic        peri_ready;

    int n_chk = 0, n_err = 0;

    // reference model state
    logic [2:0]  m_ctrl;
    logic [31:0] m_load, m_count, m_sw;
    logic        m_pend;
    int          m_phase;
    logic        exp_ready;
    logic [31:0] exp_rdata, exp_irq;

    always #5 clk = ~clk;

    peri_timer_irq #(.BASE_ADDR(BASE), .TIMER_IRQ_BIT(TBIT)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .peri_rden  (peri_rden),
        .peri_wren  (peri_wren),
        .peri_addr  (peri_addr),
        .peri_wdata (peri_wdata),
        .peri_wstrb (peri_wstrb),
        .peri_rdata (peri_rdata),
        .peri_ready (peri_ready),
        .irq_bitmap (irq_bitmap)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_ctrl = '0; m_load = '0; m_count = '0; m_sw = '0; m_pend = 1'b0;
        m_phase = 0; exp_ready = 1'b0; exp_rdata = '0; exp_irq = '0;
    endtask

    // one clock edge of the register model, using the inputs seen at that edge
    task automatic model_step();
        logic [31:0] off, msk, rv, n_count;
        logic [2:0]  n_ctrl;
        logic        acc, set_p, clr_p;
        if (!resetn) begin
            m_reset();
            return;
        end
        exp_irq       = m_sw;
        exp_irq[TBIT] = m_pend & m_ctrl[2];
        exp_irq[2:0]  = 3'b0;
        acc = (m_phase == 0) && (peri_rden || peri_wren) && (peri_addr[31:28] != 4'h0);
        off = peri_addr - BASE;
        msk = {{8{peri_wstrb[3]}}, {8{peri_wstrb[2]}}, {8{peri_wstrb[1]}}, {8{peri_wstrb[0]}}};
        rv  = 32'd0;
        if (off < 32) begin
            case (off[4:2])
                3'd0: rv = {29'b0, m_ctrl};
                3'd1: rv = m_load;
                3'd2: rv = m_count;
                3'd3: rv = {31'b0, m_pend};
                3'd4, 3'd5: rv = m_sw;
                default: rv = 32'd0;
            endcase
        end
        exp_ready = acc;
        exp_rdata = (acc && peri_rden) ? rv : 32'd0;
        m_phase   = acc ? 1 : (m_phase == 1 ? 2 : 0);

        n_ctrl = m_ctrl; n_count = m_count; set_p = 1'b0; clr_p = 1'b0;
        if (m_ctrl[0]) begin
            if (m_count == m_load) begin
                set_p = 1'b1;
                if (m_ctrl[1]) n_count = 32'd0;
                else           n_ctrl[0] = 1'b0;
            end else begin
                n_count = m_count + 32'd1;
            end
        end
        if (acc && peri_wren && off < 32) begin
            case (off[4:2])
                3'd0: n_ctrl  = (m_ctrl & ~msk[2:0]) | (peri_wdata[2:0] & msk[2:0]);
                3'd1: m_load  = (m_load & ~msk) | (peri_wdata & msk);
                3'd2: n_count = (m_count & ~msk) | (peri_wdata & msk);
                3'd3: clr_p   = peri_wdata[0] & peri_wstrb[0];
                3'd4: m_sw    = m_sw | (peri_wdata & msk);
                3'd5: m_sw    = m_sw & ~(peri_wdata & msk);
                default: ;
            endcase
        end
        m_ctrl  = n_ctrl;
        m_count = n_count;
        m_pend  = set_p | (m_pend & ~clr_p);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("ready", {31'b0, peri_ready}, {31'b0, exp_ready});
        chk("rdata", peri_rdata, exp_rdata);
        chk("irq",   irq_bitmap, exp_irq);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        peri_rden = rd; peri_wren = wr; peri_addr = a; peri_wdata = d; peri_wstrb = s;
    endtask

    // full handshake on a qualifying address; returns the acknowledged read data
    task automatic bus_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, output logic [31:0] rdat);
        int lat;
        lat  = 0;
        rdat = '0;
        drive(rd, wr, a, d, s);
        for (int i = 1; i <= 4 && lat == 0; i++) begin
            cycle();
            if (peri_ready) begin
                lat  = i;
                rdat = peri_rdata;
            end
        end
        chk("ack_lat", lat, 1);
        drive(1'b0, 1'b0, '0, '0, '0);
        cycle();
        cycle();
    endtask

    initial begin
        logic [31:0] rdat, a, d;
        logic        rd, wr;
        logic [3:0]  s;
        int          kind, n;

        m_reset();
        #1;
        chk("rst_ready", {31'b0, peri_ready}, 32'd0);
        chk("rst_rdata", peri_rdata, 32'd0);
        chk("rst_irq",   irq_bitmap, 32'd0);
        cycle(); cycle();
        resetn = 1'b1;
        cycle();

        // main-memory address is never acknowledged
        drive(1'b1, 1'b0, 32'h0000_1000, '0, '0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("lowaddr_ready", {31'b0, peri_ready}, 32'd0);
        end
        drive(1'b0, 1'b0, '0, '0, '0);
        cycle();

        // byte-strobed LOAD write
        bus_op(1'b0, 1'b1, BASE + 32'h04, 32'hAABB_CCDD, 4'b0101, rdat);
        bus_op(1'b1, 1'b0, BASE + 32'h04, '0, '0, rdat);
        chk("load_strb", rdat, 32'h00BB_00DD);

        // auto-reload expiry after 6 counting cycles
        bus_op(1'b0, 1'b1, BASE + 32'h04, 32'd5, 4'hF, rdat);
        bus_op(1'b0, 1'b1, BASE + 32'h00, 32'd7, 4'hF, rdat);
        cycle(); cycle(); cycle();
        chk("pre_pend",  {31'b0, dut.u_core.pend}, 32'd0);
        chk("pre_count", dut.u_core.count, 32'd5);
        cycle();
        chk("exp_pend",  {31'b0, dut.u_core.pend}, 32'd1);
        chk("exp_count", dut.u_core.count, 32'd0);
        cycle();
        chk("exp_irq", irq_bitmap, 32'h0000_0010);

        // STATUS clear landing on an expiry edge
        n = 0;
        while (!(m_ctrl[0] && m_count == m_load && m_phase == 0) && n < 20) begin
            cycle();
            n++;
        end
        chk("race_found", {31'b0, n < 20}, 32'd1);
        bus_op(1'b0, 1'b1, BASE + 32'h0C, 32'd1, 4'hF, rdat);
        chk("pend_race", {31'b0, dut.u_core.pend}, 32'd1);
        bus_op(1'b0, 1'b1, BASE + 32'h00, 32'd0, 4'hF, rdat);
        bus_op(1'b0, 1'b1, BASE + 32'h0C, 32'd1, 4'hF, rdat);
        bus_op(1'b1, 1'b0, BASE + 32'h0C, '0, '0, rdat);
        chk("pend_clr", rdat, 32'd0);

        // software interrupts
        bus_op(1'b0, 1'b1, BASE + 32'h10, 32'h0000_0F00, 4'hF, rdat);
        bus_op(1'b0, 1'b1, BASE + 32'h14, 32'h0000_0100, 4'hF, rdat);
        chk("sw_irq", irq_bitmap, 32'h0000_0E00);
        bus_op(1'b0, 1'b1, BASE + 32'h10, 32'h0000_0007, 4'hF, rdat);
        chk("sw_low_bits", irq_bitmap, 32'h0000_0E00);
        bus_op(1'b1, 1'b0, BASE + 32'h14, '0, '0, rdat);
        chk("sw_read", rdat & 32'hFFFF_FFF8, 32'h0000_0E00);

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            kind = $urandom_range(0, 9);
            s    = 4'($urandom_range(0, 15));
            d    = $urandom;
            rd   = 1'($urandom_range(0, 1));
            wr   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            case (kind)
                0, 1, 2, 3, 4, 5: begin
                    a = BASE + 32'(kind * 4);
                    if (kind == 0)              d = $urandom_range(0, 7);
                    if (kind == 1 || kind == 2) d = $urandom_range(0, 12);
                    bus_op(rd, wr, a, d, s, rdat);
                end
                6: bus_op(rd, wr, BASE + 32'h18 + 32'($urandom_range(0, 1) * 4), d, s, rdat);
                7: bus_op(rd, wr, 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC), d, s, rdat);
                8: begin
                    drive(rd, wr, $urandom & 32'h0FFF_FFFF, d, s);
                    n = $urandom_range(1, 3);
                    for (int i = 0; i < n; i++) cycle();
                    drive(1'b0, 1'b0, '0, '0, '0);
                    cycle();
                end
                default: begin
                    n = $urandom_range(0, 8);
                    for (int i = 0; i < n; i++) cycle();
                end
            endcase
        end

        // asynchronous reset in the middle of an acknowledge
        bus_op(1'b0, 1'b1, BASE + 32'h10, 32'h0000_0F00, 4'hF, rdat);
        bus_op(1'b0, 1'b1, BASE + 32'h08, 32'd0, 4'hF, rdat);
        bus_op(1'b0, 1'b1, BASE + 32'h04, 32'hFFFF_FFFF, 4'hF, rdat);
        bus_op(1'b0, 1'b1, BASE + 32'h00, 32'd1, 4'hF, rdat);
        cycle(); cycle();
        chk("pre_rst_irq", irq_bitmap & 32'h0000_0F00, 32'h0000_0F00);
        drive(1'b0, 1'b1, BASE + 32'h04, 32'h1234_5678, 4'hF);
        cycle();
        chk("acc_ready", {31'b0, peri_ready}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("arst_ready", {31'b0, peri_ready}, 32'd0);
        chk("arst_rdata", peri_rdata, 32'd0);
        chk("arst_irq",   irq_bitmap, 32'd0);
        chk("arst_count", dut.u_core.count, 32'd0);
        m_reset();
        drive(1'b0, 1'b0, '0, '0, '0);
        #2;
        resetn = 1'b1;
        cycle();
        bus_op(1'b1, 1'b0, BASE + 32'h04, '0, '0, rdat);
        chk("load_lost", rdat, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/peri_timer_irq.md
PERI_TIMER_IRQ -- requirements
Module: peri_timer_irq

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000, the base of the 32-byte register window.
REQ-002 SHALL have parameter TIMER_IRQ_BIT, default 4, the irq_bitmap bit driven by the timer.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports peri_rden (in, 1), peri_wren (in, 1), peri_addr (in, 32), peri_wdata (in, 32) and peri_wstrb (in, 4): the request, held by the CPU until acknowledged.
REQ-006 SHALL have port peri_rdata, output, 32: read data.
REQ-007 SHALL have port peri_ready, output, 1: one-cycle acknowledge.
REQ-008 SHALL have port irq_bitmap, output, 32: the interrupt lines to the CPU.

Function
REQ-009 SHALL ignore any request with peri_addr[31:28]==0, which main memory serves; such a request SHALL never assert peri_ready.
REQ-010 SHALL decode the registers at word offsets from BASE_ADDR: 0x00 CTRL, 0x04 LOAD, 0x08 COUNT, 0x0C STATUS, 0x10 SWIRQ_SET, 0x14 SWIRQ_CLR.
REQ-011 CTRL SHALL contain bit0 EN, bit1 AUTO_RELOAD and bit2 IRQ_EN; all other bits SHALL read 0.
REQ-012 SHALL run a handshake FSM with states IDLE, ACK and GAP: IDLE->ACK when (peri_rden|peri_wren) is high and the address qualifies; ACK->GAP unconditionally; GAP->IDLE unconditionally.
REQ-013 peri_ready SHALL be 1 only in ACK, so an accepted request is acknowledged exactly one cycle after it is sampled.
REQ-014 peri_rdata SHALL be registered, valid during ACK, and 0 in every other state.
REQ-015 A write SHALL commit on the IDLE->ACK edge and SHALL honour peri_wstrb per byte lane; bytes whose strobe is 0 SHALL be unchanged.
REQ-016 A qualifying address outside the window (top nibble nonzero) SHALL be acknowledged with rdata 0, and a write to it SHALL be ignored.
REQ-017 Reads of SWIRQ_SET and SWIRQ_CLR SHALL return the current software-pending bits.
REQ-018 While EN=1, COUNT SHALL increment by 1 every cycle, wrapping modulo 2^32.
REQ-019 When EN=1 and COUNT==LOAD, STATUS.PEND SHALL be set.
REQ-020 At the COUNT==LOAD match, COUNT SHALL go to 0 if AUTO_RELOAD=1; otherwise COUNT SHALL hold and EN SHALL clear.
REQ-021 A bus write to COUNT or CTRL SHALL take priority over the timer update in the same cycle.
REQ-022 Writing 1 to STATUS bit0 SHALL clear PEND; if an expiry occurs in the same cycle, the set SHALL win.
REQ-023 A write to SWIRQ_SET SHALL OR its data into the software-pending bits, subject to the byte strobes.
REQ-024 A write to SWIRQ_CLR SHALL clear the software-pending bits written as 1.
REQ-025 irq_bitmap SHALL be registered: irq_bitmap[TIMER_IRQ_BIT] = PEND & IRQ_EN, other bits come from software pending, and bits [2:0] SHALL always be 0.
REQ-026 A request arriving while the FSM is in ACK or GAP SHALL wait until IDLE.

Reset
REQ-027 On resetn low, the block SHALL asynchronously return to IDLE, drive peri_ready=0, peri_rdata=0 and irq_bitmap=0, and clear CTRL, LOAD, COUNT, PEND and software pending.
REQ-028 Reset during ACK SHALL abort the acknowledge; a write already committed SHALL be lost to reset.

Structure
REQ-029 A shared package SHALL hold the register offsets, the CTRL bit indices and the FSM state encodings.
REQ-030 The counter, LOAD compare and reload logic SHALL be a sub-module named peri_timer_core; bus decode and the FSM SHALL remain in the top.

Verification
REQ-031 Write LOAD=5, then CTRL=0x7 -> PEND sets after 6 counting cycles, irq_bitmap=0x10, and COUNT returns to 0.
REQ-032 Read of 0x0000_1000 held for 10 cycles -> peri_ready stays 0 throughout.
REQ-033 Write 0xAABBCCDD to LOAD with wstrb=4'b0101 (initial LOAD=0) -> reading LOAD returns 0x00BB00DD, with ready asserted exactly one cycle after the request.
REQ-034 With PEND=1 and IRQ_EN=1, write 1 to STATUS in the same cycle as an expiry -> PEND stays 1.
REQ-035 Write 0x0000_0F00 to SWIRQ_SET, then 0x0000_0100 to SWIRQ_CLR -> irq_bitmap=0x0000_0E00; then write 0x7 to SWIRQ_SET -> bits [2:0] stay 0.
REQ-036 Assert resetn=0 mid-ACK while counting -> peri_ready=0, COUNT=0 and irq_bitmap=0 immediately, without waiting for a clock edge.
